// File: rtl/spi_ram_loader.sv
// -----------------------------------------------------------------------------
// spi_ram_loader
//
// Byte-stream program loader that sits in front of the SPI RAM controller.
// While load_en is high the loader owns the RAM request port. It takes a
// 16-bit start address (high byte first), packs the following bytes
// big-endian into 16-bit words, and writes each word to successive
// addresses (start, start+ADDR_STEP, ...). While the loader is idle and
// load_en is low, the cpu's RAM request port passes straight through.
//
// Optional feature:
//   SPI_RAM_LOADER_VERIFY_EN : when defined, every written word is read back
//   and compared. A mismatch sets the sticky load_error flag.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load_en             high = loader owns the RAM port, cpu held
//   byte_in/byte_valid  host byte stream; transfer on byte_valid & byte_ready
//   byte_ready          loader accepts a byte this cycle
//   cpu_hold            stall request for the cpu
//   words_written       words committed since the last load_en rise
//   load_error          sticky: partial word abandoned (or verify mismatch)
//   cpu_*               cpu-side RAM request port (pass-through source)
//   ram_*               controller-side RAM request port
// -----------------------------------------------------------------------------
module spi_ram_loader #(
  parameter logic [15:0] ADDR_STEP = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cpu_hold,
  output logic [15:0] words_written,
  output logic        load_error,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_start_read,
  input  logic        cpu_start_write,
  output logic [15:0] cpu_rdata,
  output logic        cpu_busy,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_start_read,
  output logic        ram_start_write,
  input  logic [15:0] ram_rdata,
  input  logic        ram_busy
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_WAIT    = 4'd6,
    S_VRD     = 4'd7,
    S_VWAIT   = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] words_q, words_d;
  logic        err_q, err_d;
  // Marks the first cycle after a start pulse, during which ram_busy has
  // not yet risen and must not be taken as completion.
  logic        first_q, first_d;

  logic        byte_ready_s;
  logic        byte_take_s;
  logic        wr_start_s;
  logic        rd_start_s;
  logic        pass_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      hi_q    <= 8'd0;
      lo_q    <= 8'd0;
      words_q <= 16'd0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      words_q <= words_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Byte acceptance depends only on state and load_en, never on byte_valid.
  always_comb begin
    byte_ready_s = 1'b0;
    if (load_en) begin
      case (state_q)
        S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO: byte_ready_s = 1'b1;
        default:                                    byte_ready_s = 1'b0;
      endcase
    end else begin
      byte_ready_s = 1'b0;
    end
  end

  assign byte_take_s = byte_valid & byte_ready_s;

  // Next-state logic and RAM start pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    words_d    = words_q;
    err_d      = err_q;
    first_d    = first_q;
    wr_start_s = 1'b0;
    rd_start_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d = S_ADDR_HI;
          words_d = 16'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR_HI: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (byte_take_s) begin
          addr_d[15:8] = byte_in;
          state_d      = S_ADDR_LO;
        end else begin
          state_d = S_ADDR_HI;
        end
      end

      S_ADDR_LO: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (byte_take_s) begin
          addr_d[7:0] = byte_in;
          state_d     = S_DATA_HI;
        end else begin
          state_d = S_ADDR_LO;
        end
      end

      S_DATA_HI: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (byte_take_s) begin
          hi_d    = byte_in;
          state_d = S_DATA_LO;
        end else begin
          state_d = S_DATA_HI;
        end
      end

      S_DATA_LO: begin
        // Abandoning a half word is the one exit that flags an error.
        if (!load_en) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (byte_take_s) begin
          lo_d    = byte_in;
          state_d = S_WRITE;
        end else begin
          state_d = S_DATA_LO;
        end
      end

      S_WRITE: begin
        // The write is committed even if load_en drops while waiting here.
        if (!ram_busy) begin
          wr_start_s = 1'b1;
          first_d    = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_WAIT: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!ram_busy) begin
`ifdef SPI_RAM_LOADER_VERIFY_EN
          state_d = S_VRD;
`else
          addr_d  = addr_q + ADDR_STEP;
          words_d = words_q + 16'd1;
          state_d = load_en ? S_DATA_HI : S_IDLE;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end

`ifdef SPI_RAM_LOADER_VERIFY_EN
      S_VRD: begin
        if (!ram_busy) begin
          rd_start_s = 1'b1;
          first_d    = 1'b1;
          state_d    = S_VWAIT;
        end else begin
          state_d = S_VRD;
        end
      end

      S_VWAIT: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!ram_busy) begin
          if (ram_rdata != {hi_q, lo_q}) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          addr_d  = addr_q + ADDR_STEP;
          words_d = words_q + 16'd1;
          state_d = load_en ? S_DATA_HI : S_IDLE;
        end else begin
          state_d = S_VWAIT;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pass_s = (state_q == S_IDLE) && !load_en;

  // RAM port mux: cpu pass-through when idle, loader-driven otherwise.
  always_comb begin
    ram_addr        = addr_q;
    ram_wdata       = {hi_q, lo_q};
    ram_start_read  = 1'b0;
    ram_start_write = 1'b0;
    cpu_busy        = 1'b1;
    if (pass_s) begin
      ram_addr        = cpu_addr;
      ram_wdata       = cpu_wdata;
      ram_start_read  = cpu_start_read;
      ram_start_write = cpu_start_write;
      cpu_busy        = ram_busy;
    end else begin
      ram_addr        = addr_q;
      ram_wdata       = {hi_q, lo_q};
      ram_start_read  = rd_start_s;
      ram_start_write = wr_start_s;
      cpu_busy        = 1'b1;
    end
  end

  assign cpu_rdata     = ram_rdata;
  assign byte_ready    = byte_ready_s;
  assign cpu_hold      = (state_q != S_IDLE) || load_en;
  assign words_written = words_q;
  assign load_error    = err_q;

endmodule

// File: tb/tb_spi_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_loader
//
// Scoreboard bench for spi_ram_loader. A load is described as a start address
// plus a list of data bytes; the reference model turns that into the list of
// (address, word) writes it must produce and queues them. A monitor pops and
// compares every ram_start_write the DUT issues. A simple RAM model with
// randomised latency answers the controller-side handshake.
// -----------------------------------------------------------------------------
module tb_spi_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        cpu_hold;
  logic [15:0] words_written;
  logic        load_error;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_start_read;
  logic        cpu_start_write;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_start_read;
  logic        ram_start_write;
  logic [15:0] ram_rdata;
  logic        ram_busy;

  always #5 clk = ~clk;

  spi_ram_loader dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cpu_hold(cpu_hold), .words_written(words_written), .load_error(load_error),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_start_read(cpu_start_read), .cpu_start_write(cpu_start_write),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_start_read(ram_start_read), .ram_start_write(ram_start_write),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [15:0] mem [0:65535];
  int          busy_cnt;
  int          ram_stretch = 0;   // >0: fixed busy length, else random 1..4
  logic        corrupt = 1'b0;    // flip bit 0 on readback

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_busy  <= 1'b0;
      busy_cnt  <= 0;
      ram_rdata <= 16'd0;
    end else if (ram_start_write || ram_start_read) begin
      ram_busy <= 1'b1;
      busy_cnt <= (ram_stretch > 0) ? ram_stretch - 1 : int'($urandom_range(0, 3));
      if (ram_start_write) mem[ram_addr] <= ram_wdata;
      if (ram_start_read)  ram_rdata <= mem[ram_addr] ^ {15'd0, corrupt};
    end else if (ram_busy) begin
      if (busy_cnt == 0) ram_busy <= 1'b0;
      else               busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];
  int  hs_count = 0;

  // Monitor: counts byte handshakes and checks every issued write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (byte_valid && byte_ready) hs_count++;
      if (ram_start_write) begin
        chk("start_while_busy", {31'd0, ram_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {16'd0, ram_addr}, {16'd0, e.a});
          chk("write_data", {16'd0, ram_wdata}, {16'd0, e.d});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] dbytes [0:15];
  int         wait_at [0:17];

  task automatic send_byte(input logic [7:0] b, output int waited);
    bit done;
    waited = 0;
    done = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!done && waited < 500) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte 0x%0h not accepted in 500 cycles", b);
    end
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!cpu_hold) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: cpu_hold still 1 after 400 cycles", name);
    end
  endtask

  // Reference model + driver for one complete load session.
  task automatic run_load(input string name, input logic [15:0] start, input int n);
    int hs0;
    int w;
    int exp_ww;
    bit exp_err;
    wr_t e;
    exp_ww = n / 2;
    exp_err = (n % 2) != 0;
    if (corrupt && exp_ww > 0) exp_err = 1'b1;
    for (int i = 0; i < exp_ww; i++) begin
      e.a = start + 16'(2 * i);
      e.d = {dbytes[2*i], dbytes[2*i+1]};
      exp_q.push_back(e);
    end
    hs0 = hs_count;
    load_en = 1'b1;
    @(posedge clk); #1;
    chk({name, "_err_cleared"}, {31'd0, load_error}, 32'd0);
    chk({name, "_ww_cleared"}, {16'd0, words_written}, 32'd0);
    send_byte(start[15:8], wait_at[0]);
    send_byte(start[7:0], wait_at[1]);
    for (int i = 0; i < n; i++) send_byte(dbytes[i], wait_at[i+2]);
    load_en = 1'b0;
    wait_idle(name);
    w = exp_ww;
    chk({name, "_words_written"}, {16'd0, words_written}, 32'(w));
    chk({name, "_load_error"}, {31'd0, load_error}, {31'd0, exp_err});
    chk({name, "_handshakes"}, 32'(hs_count - hs0), 32'(n + 2));
    chk({name, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    load_en = 1'b0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    cpu_addr = 16'd0;
    cpu_wdata = 16'd0;
    cpu_start_read = 1'b0;
    cpu_start_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    chk("rst_error", {31'd0, load_error}, 32'd0);
    chk("rst_start_w", {31'd0, ram_start_write}, 32'd0);
    chk("rst_start_r", {31'd0, ram_start_read}, 32'd0);

    // Basic two-word load.
    dbytes[0] = 8'h12; dbytes[1] = 8'h34; dbytes[2] = 8'hAB; dbytes[3] = 8'hCD;
    run_load("t1", 16'h0010, 4);

    // Address wraps modulo 2^16.
    dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33; dbytes[3] = 8'h44;
    run_load("t2", 16'hFFFE, 4);

    // Half word abandoned: no write, sticky error.
    dbytes[0] = 8'h55;
    run_load("t3", 16'h0000, 1);

    // Byte held while the RAM is stretched; next load also clears t3's error.
    ram_stretch = 20;
    dbytes[0] = 8'h12; dbytes[1] = 8'h34; dbytes[2] = 8'h77; dbytes[3] = 8'h88;
    run_load("t4", 16'h0100, 4);
    ram_stretch = 0;
    checks++;
    if (wait_at[4] < 20) begin
      errors++;
      $display("FAIL t4_ready_low: byte 77 waited %0d cycles, required at least 20", wait_at[4]);
    end

    // cpu pass-through and blocking.
    @(posedge clk); #1;
    cpu_addr = 16'h0040;
    cpu_start_read = 1'b1;
    @(negedge clk);
    chk("t5_pass_start", {31'd0, ram_start_read}, 32'd1);
    chk("t5_pass_addr", {16'd0, ram_addr}, 32'h0040);
    chk("t5_pass_busy", {31'd0, cpu_busy}, {31'd0, ram_busy});
    @(posedge clk); #1;
    cpu_start_read = 1'b0;
    repeat (8) @(posedge clk);
    #1 load_en = 1'b1;
    @(posedge clk); #1;
    cpu_start_read = 1'b1;
    @(negedge clk);
    chk("t5_blocked_start", {31'd0, ram_start_read}, 32'd0);
    chk("t5_blocked_busy", {31'd0, cpu_busy}, 32'd1);
    @(posedge clk); #1;
    cpu_start_read = 1'b0;
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_back_idle", {31'd0, cpu_hold}, 32'd0);

    // Randomised loads.
    for (int r = 0; r < 12; r++) begin
      int n;
      logic [15:0] s;
      n = int'($urandom_range(0, 9));
      s = 16'($urandom);
      for (int i = 0; i < n; i++) dbytes[i] = 8'($urandom);
      run_load("rnd", s, n);
    end

    // Reset while the loader waits on the RAM.
    begin
      wr_t e;
      int wdummy;
      e.a = 16'h2000;
      e.d = 16'hDEAD;
      exp_q.push_back(e);
      load_en = 1'b1;
      send_byte(8'h20, wdummy);
      send_byte(8'h00, wdummy);
      send_byte(8'hDE, wdummy);
      send_byte(8'hAD, wdummy);
      @(posedge clk); #1;
      rst_n = 1'b0;
      load_en = 1'b0;
      @(posedge clk); #1;
      chk("t6_words", {16'd0, words_written}, 32'd0);
      chk("t6_error", {31'd0, load_error}, 32'd0);
      chk("t6_ready", {31'd0, byte_ready}, 32'd0);
      chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
      chk("t6_start_w", {31'd0, ram_start_write}, 32'd0);
      chk("t6_cpu_busy", {31'd0, cpu_busy}, 32'd0);
      chk("t6_write_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
    end

`ifdef SPI_RAM_LOADER_VERIFY_EN
    // Readback corrupted in bit 0 must raise load_error.
    corrupt = 1'b1;
    dbytes[0] = 8'h01; dbytes[1] = 8'h02;
    run_load("t7", 16'h3000, 2);
    corrupt = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
